// File: rtl/ctrl_pipe_reg.sv
// ctrl_pipe_reg: stallable/flushable control-bundle pipeline with bubble gating.
// Define CTRL_PIPE_STALL_CNT_EN to add the saturating stall_cnt output.
module ctrl_pipe_reg #(
    parameter int WIDTH = 16,
    parameter int STAGES = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_ctrl,
    input  logic             stall,
    input  logic             flush,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_ctrl,
    output logic [2:0]       occupancy
`ifdef CTRL_PIPE_STALL_CNT_EN
    ,
    output logic [15:0]      stall_cnt
`endif
);
    logic [STAGES-1:0] v;
    logic [WIDTH-1:0]  c [STAGES];
    logic [STAGES-1:0] v_in;
    logic [WIDTH-1:0]  c_in [STAGES];

    always_comb begin
        v_in[0] = in_valid;
        c_in[0] = in_ctrl;
        for (int i = 1; i < STAGES; i++) begin
            v_in[i] = v[i-1];
            c_in[i] = c[i-1];
        end
    end

    // Invalid entries store RESET_VAL so a bubble never carries live strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n || flush) begin
            v <= '0;
            for (int i = 0; i < STAGES; i++) c[i] <= RESET_VAL;
        end else if (!stall) begin
            v <= v_in;
            for (int i = 0; i < STAGES; i++) c[i] <= v_in[i] ? c_in[i] : RESET_VAL;
        end
    end

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < STAGES; i++) occupancy = occupancy + 3'(v[i]);
    end

    assign out_valid = v[STAGES-1];
    assign out_ctrl  = v[STAGES-1] ? c[STAGES-1] : RESET_VAL;

`ifdef CTRL_PIPE_STALL_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            stall_cnt <= '0;
        else if (flush)
            stall_cnt <= '0;
        else if (stall && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_ctrl_pipe_reg.sv
// tb_ctrl_pipe_reg: directed checks of ctrl_pipe_reg at STAGES 1/2/3 and a non-zero RESET_VAL.
module tb_ctrl_pipe_reg;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic in_valid = 1'b0;
    logic [15:0] in_ctrl = '0;
    logic stall = 1'b0;
    logic flush = 1'b0;
    logic ov1, ov2, ov3, ovr;
    logic [15:0] oc1, oc2, oc3, ocr;
    logic [2:0] oq1, oq2, oq3, oqr;
    int n_chk = 0;
    int n_fail = 0;
`ifdef CTRL_PIPE_STALL_CNT_EN
    logic [15:0] sc1, sc2, sc3, scr;
`endif

    always #5 clk = ~clk;

    ctrl_pipe_reg #(.WIDTH(16), .STAGES(1)) d1 (.clk(clk), .reset_n(reset_n), .in_valid(in_valid),
        .in_ctrl(in_ctrl), .stall(stall), .flush(flush), .out_valid(ov1), .out_ctrl(oc1), .occupancy(oq1)
`ifdef CTRL_PIPE_STALL_CNT_EN
        , .stall_cnt(sc1)
`endif
    );
    ctrl_pipe_reg #(.WIDTH(16), .STAGES(2)) d2 (.clk(clk), .reset_n(reset_n), .in_valid(in_valid),
        .in_ctrl(in_ctrl), .stall(stall), .flush(flush), .out_valid(ov2), .out_ctrl(oc2), .occupancy(oq2)
`ifdef CTRL_PIPE_STALL_CNT_EN
        , .stall_cnt(sc2)
`endif
    );
    ctrl_pipe_reg #(.WIDTH(16), .STAGES(3)) d3 (.clk(clk), .reset_n(reset_n), .in_valid(in_valid),
        .in_ctrl(in_ctrl), .stall(stall), .flush(flush), .out_valid(ov3), .out_ctrl(oc3), .occupancy(oq3)
`ifdef CTRL_PIPE_STALL_CNT_EN
        , .stall_cnt(sc3)
`endif
    );
    ctrl_pipe_reg #(.WIDTH(16), .STAGES(2), .RESET_VAL(16'h0100)) dr (.clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ctrl(in_ctrl), .stall(stall), .flush(flush), .out_valid(ovr),
        .out_ctrl(ocr), .occupancy(oqr)
`ifdef CTRL_PIPE_STALL_CNT_EN
        , .stall_cnt(scr)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        in_valid = 1'b0;
        stall = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_chk++; if (ov1 !== 1'b0) begin n_fail++; $display("FAIL reset_ov1 got %b exp 0", ov1); end
        n_chk++; if (oq3 !== 3'd0) begin n_fail++; $display("FAIL reset_oq3 got %0d exp 0", oq3); end
        n_chk++; if (oc3 !== 16'h0000) begin n_fail++; $display("FAIL reset_oc3 got %h exp 0000", oc3); end
        n_chk++; if (ocr !== 16'h0100) begin n_fail++; $display("FAIL reset_ocr got %h exp 0100", ocr); end
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_ctrl = 16'hA5C3;
        step();
        n_chk++; if (ov1 !== 1'b1) begin n_fail++; $display("FAIL single_ov got %b exp 1", ov1); end
        n_chk++; if (oc1 !== 16'hA5C3) begin n_fail++; $display("FAIL single_oc got %h exp a5c3", oc1); end
        in_valid = 1'b0;
        step();
        n_chk++; if (ov1 !== 1'b0) begin n_fail++; $display("FAIL bubble_ov got %b exp 0", ov1); end
        n_chk++; if (oc1 !== 16'h0000) begin n_fail++; $display("FAIL bubble_oc got %h exp 0000", oc1); end
    endtask

    task automatic test_latency();
        logic [2:0]  e_q [6] = '{3'd1, 3'd2, 3'd3, 3'd2, 3'd1, 3'd0};
        logic        e_v [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [15:0] e_c [6] = '{16'h0, 16'h0, 16'h1, 16'h2, 16'h3, 16'h0};
        clear();
        for (int i = 0; i < 6; i++) begin
            in_valid = (i < 3);
            in_ctrl = 16'(i + 1);
            step();
            n_chk++; if (oq3 !== e_q[i]) begin n_fail++; $display("FAIL lat_occ[%0d] got %0d exp %0d", i, oq3, e_q[i]); end
            n_chk++; if (ov3 !== e_v[i]) begin n_fail++; $display("FAIL lat_ov[%0d] got %b exp %b", i, ov3, e_v[i]); end
            n_chk++; if (oc3 !== e_c[i]) begin n_fail++; $display("FAIL lat_oc[%0d] got %h exp %h", i, oc3, e_c[i]); end
            if (i == 1) begin
                n_chk++; if (oc2 !== 16'h0001) begin n_fail++; $display("FAIL lat2_oc got %h exp 0001", oc2); end
            end
        end
    endtask

    task automatic test_stall();
        clear();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_ctrl = 16'(16'h11 * (i + 1));
            step();
        end
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_ctrl = 16'hF0F0 ^ 16'(i);
            step();
            n_chk++; if (oc3 !== 16'h0011) begin n_fail++; $display("FAIL stall_oc[%0d] got %h exp 0011", i, oc3); end
            n_chk++; if (oq3 !== 3'd3) begin n_fail++; $display("FAIL stall_occ[%0d] got %0d exp 3", i, oq3); end
        end
`ifdef CTRL_PIPE_STALL_CNT_EN
        n_chk++; if (sc3 !== 16'd4) begin n_fail++; $display("FAIL stall_cnt got %0d exp 4", sc3); end
`endif
        stall = 1'b0; in_valid = 1'b0;
        step();
        n_chk++; if (oc3 !== 16'h0022) begin n_fail++; $display("FAIL resume_oc got %h exp 0022", oc3); end
        n_chk++; if (oq3 !== 3'd2) begin n_fail++; $display("FAIL resume_occ got %0d exp 2", oq3); end
    endtask

    task automatic test_flush_stall();
        clear();
        in_valid = 1'b1; in_ctrl = 16'h0044; step();
        in_ctrl = 16'h0055; step();
        n_chk++; if (oq2 !== 3'd2) begin n_fail++; $display("FAIL pre_flush_occ got %0d exp 2", oq2); end
        stall = 1'b1; flush = 1'b1;
        step();
        n_chk++; if (oq2 !== 3'd0) begin n_fail++; $display("FAIL flush_occ got %0d exp 0", oq2); end
        n_chk++; if (ov2 !== 1'b0) begin n_fail++; $display("FAIL flush_ov got %b exp 0", ov2); end
        n_chk++; if (oc2 !== 16'h0000) begin n_fail++; $display("FAIL flush_oc got %h exp 0000", oc2); end
        n_chk++; if (ocr !== 16'h0100) begin n_fail++; $display("FAIL flush_ocr got %h exp 0100", ocr); end
`ifdef CTRL_PIPE_STALL_CNT_EN
        n_chk++; if (sc2 !== 16'd0) begin n_fail++; $display("FAIL flush_stall_cnt got %0d exp 0", sc2); end
`endif
        stall = 1'b0; flush = 1'b0;
    endtask

    task automatic test_async_reset();
        clear();
        in_valid = 1'b1; in_ctrl = 16'h0066; step();
        in_ctrl = 16'h0077; step();
        stall = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        n_chk++; if (oq2 !== 3'd0) begin n_fail++; $display("FAIL areset_occ got %0d exp 0", oq2); end
        n_chk++; if (ov2 !== 1'b0) begin n_fail++; $display("FAIL areset_ov got %b exp 0", ov2); end
        step();
        reset_n = 1'b1; stall = 1'b0; in_ctrl = 16'h0088;
        step();
        n_chk++; if (oc1 !== 16'h0088) begin n_fail++; $display("FAIL post_reset_oc got %h exp 0088", oc1); end
    endtask

    task automatic test_bubble_resetval();
        clear();
        in_valid = 1'b0; in_ctrl = 16'hFFFF;
        step(); step();
        n_chk++; if (ocr !== 16'h0100) begin n_fail++; $display("FAIL rv_bubble_oc got %h exp 0100", ocr); end
        n_chk++; if (ovr !== 1'b0) begin n_fail++; $display("FAIL rv_bubble_ov got %b exp 0", ovr); end
        n_chk++; if (oc1 !== 16'h0000) begin n_fail++; $display("FAIL rv_d1_oc got %h exp 0000", oc1); end
        in_valid = 1'b1; in_ctrl = 16'hBEEF;
        step();
        in_valid = 1'b0;
        step();
        n_chk++; if (ocr !== 16'hBEEF) begin n_fail++; $display("FAIL rv_live_oc got %h exp beef", ocr); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_latency();
        test_stall();
        test_flush_stall();
        test_async_reset();
        test_bubble_resetval();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ctrl_pipe_reg.md
CTRL_PIPE_REG -- requirements
Module: ctrl_pipe_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the control-bundle width in bits (legal range 1..64).
REQ-002 The block SHALL have parameter STAGES, default 1, giving the number of register stages (legal range 1..4).
REQ-003 The block SHALL have parameter RESET_VAL, default all-zeros, WIDTH bits, giving the bubble/reset value of the control bundle.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all flops SHALL be rising-edge.
REQ-005 The block SHALL have port reset_n, input, 1, an asynchronous active-low reset.
REQ-006 The block SHALL have port in_valid, input, 1, marking in_ctrl as a live instruction.
REQ-007 The block SHALL have port in_ctrl, input, WIDTH, the control bundle (write enables, selects, CSR/UART strobes).
REQ-008 The block SHALL have port stall, input, 1, which freezes every stage.
REQ-009 The block SHALL have port flush, input, 1, which kills every stage.
REQ-010 The block SHALL have port out_valid, input-side-free output, 1, the valid bit of the last stage.
REQ-011 The block SHALL have port out_ctrl, output, WIDTH, the gated control bundle of the last stage.
REQ-012 The block SHALL have port occupancy, output, 3, the count of stages currently holding valid=1.

Function
REQ-013 Each stage k SHALL hold one valid bit v[k] and one WIDTH-bit register c[k]; stage 0 SHALL load from in_valid/in_ctrl, and stage k SHALL load from stage k-1.
REQ-014 When stall=0 and flush=0, every stage SHALL advance on each rising clk edge, giving a latency of exactly STAGES cycles from in_* to out_*.
REQ-015 When stall=1 and flush=0, every v[k] and c[k] SHALL hold its value, and in_* SHALL be ignored.
REQ-016 When flush=1, on the next edge every v[k] SHALL become 0 and every c[k] SHALL become RESET_VAL, regardless of stall (flush has priority over stall).
REQ-017 A stage loading from an input with valid=0 SHALL store RESET_VAL in c[k], not the input bundle.
REQ-018 out_ctrl SHALL equal c[STAGES-1] when out_valid=1 and RESET_VAL otherwise, so a bubble never asserts a write enable.
REQ-019 out_valid SHALL equal v[STAGES-1] combinationally.
REQ-020 occupancy SHALL equal the population count of v[0..STAGES-1], zero-extended to 3 bits, and SHALL be registered-state derived only (no combinational path from inputs).
REQ-021 There SHALL be no combinational path from any input to out_valid or out_ctrl.

Reset
REQ-022 While reset_n=0, all v[k] SHALL be 0 and all c[k] SHALL be RESET_VAL asynchronously; out_valid=0, out_ctrl=RESET_VAL, occupancy=0.
REQ-023 Reset asserted mid-stall or mid-flush SHALL override both; after deassertion the first edge SHALL obey REQ-014..REQ-016 normally.
REQ-024 reset_n deassertion SHALL be synchronised externally; the block SHALL add no reset synchroniser.

Configuration
REQ-025 When macro CTRL_PIPE_STALL_CNT_EN is defined, the block SHALL add output stall_cnt, 16 bits, counting clk edges with stall=1 and flush=0, saturating at 0xFFFF, cleared to 0 by reset_n or by flush=1.
REQ-026 When CTRL_PIPE_STALL_CNT_EN is not defined, port stall_cnt and its counter SHALL not exist, and all other behaviour SHALL be identical.

Verification
REQ-027 STAGES=1, WIDTH=16: in_valid=1, in_ctrl=0xA5C3 for one cycle -> next cycle out_valid=1, out_ctrl=0xA5C3; following cycle with in_valid=0 -> out_valid=0, out_ctrl=0x0000.
REQ-028 STAGES=3: feed 0x0001,0x0002,0x0003 valid on consecutive cycles -> they emerge on cycles 3,4,5; occupancy reaches 3 on cycle 3.
REQ-029 STAGES=3 holding 3 valid entries, stall=1 for 4 cycles with in_ctrl changing -> out_ctrl and occupancy unchanged; with CTRL_PIPE_STALL_CNT_EN, stall_cnt=4.
REQ-030 STAGES=2, stall=1 and flush=1 on same edge -> next cycle occupancy=0, out_valid=0, out_ctrl=RESET_VAL, stall_cnt=0.
REQ-031 Assert reset_n=0 between clock edges while occupancy=2 -> out_valid=0 and occupancy=0 immediately, before the next clk edge.
REQ-032 RESET_VAL=0x0100, in_valid=0 with in_ctrl=0xFFFF -> out_ctrl=0x0100 after STAGES cycles.
